// File: rtl/vga_timing_pkg.sv
// Shared definitions for the raster timing generator.
//   state_t     : run-control FSM encoding (IDLE, RUN, DRAIN)
//   DEF_*       : default 640x480@60 geometry and sync delay
//   span_total  : active + porches + sync for one axis
//   sync_begin  : first count inside the sync pulse
//   sync_end    : first count after the sync pulse
package vga_timing_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int unsigned DEF_H_ACTIVE   = 640;
    localparam int unsigned DEF_H_FP       = 16;
    localparam int unsigned DEF_H_SYNC     = 96;
    localparam int unsigned DEF_H_BP       = 48;
    localparam int unsigned DEF_V_ACTIVE   = 480;
    localparam int unsigned DEF_V_FP       = 10;
    localparam int unsigned DEF_V_SYNC     = 2;
    localparam int unsigned DEF_V_BP       = 33;
    localparam int unsigned DEF_SYNC_DELAY = 1;

    function automatic int unsigned span_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned sync_begin(input int unsigned active, input int unsigned fp);
        return active + fp;
    endfunction

    function automatic int unsigned sync_end(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync);
        return active + fp + sync;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the generator and its pixel consumers.
//   enable      : run request (driven by the consumer side)
//   DrawX/DrawY : current raster position
//   blank       : 1 = active video
//   hs/vs       : active-low syncs, delayed to line up with registered colour
//   line_start  : pulse at DrawX==0
//   frame_start : pulse at DrawX==0 && DrawY==0
//   frame_count : number of frame_start pulses seen, modulo 256
// Modports: master = timing generator, slave = consumer.
interface vga_timing_gen_if;

    logic       enable;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        input  enable,
        output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

    modport slave (
        output enable,
        input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

endinterface

// File: rtl/vga_sync_delay.sv
// Shift register that delays the sync pair by DEPTH clocks.
//   clk, rst_n : clock, asynchronous active-low reset (stages reset to all ones)
//   raw        : undelayed input
//   delayed    : raw delayed DEPTH cycles; DEPTH=0 is a wire
module vga_sync_delay #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] delayed
);

    if (DEPTH == 0) begin : g_pass
        assign delayed = raw;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage[i] <= '1;
                end
            end else begin
                stage[0] <= raw;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign delayed = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: counts DrawX/DrawY, decodes blank/line_start/frame_start,
// produces delayed hs/vs and a frame counter. Starts and stops only on frame
// boundaries.
//   vga_clk : pixel clock
//   reset_n : asynchronous active-low reset
//   vga     : timing bundle (master side), carries enable in and all timing out
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int unsigned SYNC_DELAY = DEF_SYNC_DELAY
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 1024) begin : g_h_chk
        $fatal(1, "vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_chk
        $fatal(1, "vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if (SYNC_DELAY > 4) begin : g_d_chk
        $fatal(1, "vga_timing_gen: SYNC_DELAY must be 0..4");
    end

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    // 11-bit bounds so a window ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_B   = 11'(sync_begin(H_ACTIVE, H_FP));
    localparam logic [10:0] HS_E   = 11'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [10:0] VS_B   = 11'(sync_begin(V_ACTIVE, V_FP));
    localparam logic [10:0] VS_E   = 11'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    state_t     state, state_n;
    logic [9:0] x_q, y_q, x_n, y_n;
    logic       blank_q, line_start_q, frame_start_q;
    logic [7:0] frame_count_q;
    logic       at_end, running_n;
    logic [1:0] sync_raw, sync_dly;

    assign at_end    = (x_q == H_LAST) && (y_q == V_LAST);
    assign running_n = (state_n != IDLE);

    always_comb begin
        state_n = state;
        x_n     = x_q;
        y_n     = y_q;
        unique case (state)
            IDLE: begin
                if (vga.enable) begin
                    state_n = RUN;
                    x_n     = '0;
                    y_n     = '0;
                end
            end
            RUN, DRAIN: begin
                if (at_end && !vga.enable) begin
                    state_n = IDLE;
                    x_n     = '0;
                    y_n     = '0;
                end else begin
                    state_n = vga.enable ? RUN : DRAIN;
                    if (x_q == H_LAST) begin
                        x_n = '0;
                        y_n = (y_q == V_LAST) ? '0 : y_q + 10'd1;
                    end else begin
                        x_n = x_q + 10'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Flags decode from the next-state counters so they line up with DrawX/DrawY.
    // frame_count advances on the edge after each frame_start pulse, i.e. it
    // shows the number of frames begun before the current one.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state         <= state_n;
            x_q           <= x_n;
            y_q           <= y_n;
            blank_q       <= running_n && ({1'b0, x_n} < H_ACT) && ({1'b0, y_n} < V_ACT);
            line_start_q  <= running_n && (x_n == '0);
            frame_start_q <= running_n && (x_n == '0) && (y_n == '0);
            frame_count_q <= frame_count_q + {7'd0, frame_start_q};
        end
    end

    // Idle forces the raw syncs high so the delay line refills with ones.
    assign sync_raw[1] = !((state != IDLE) && ({1'b0, x_q} >= HS_B) && ({1'b0, x_q} < HS_E));
    assign sync_raw[0] = !((state != IDLE) && ({1'b0, y_q} >= VS_B) && ({1'b0, y_q} < VS_E));

    vga_sync_delay #(
        .WIDTH (2),
        .DEPTH (SYNC_DELAY)
    ) u_sync_delay (
        .clk     (vga_clk),
        .rst_n   (reset_n),
        .raw     (sync_raw),
        .delayed (sync_dly)
    );

    assign vga.DrawX       = x_q;
    assign vga.DrawY       = y_q;
    assign vga.blank       = blank_q;
    assign vga.hs          = sync_dly[1];
    assign vga.vs          = sync_dly[0];
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default geometry instance (a) with SYNC_DELAY=1 and
// a small-geometry instance (b) with SYNC_DELAY=2. A cycle model per instance
// pushes expected outputs at each clock edge; they are popped and compared on
// the falling edge. Directed event-timing checks run alongside.
module tb_vga_timing_gen;

    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if va ();
    vga_timing_gen_if vb ();

    vga_timing_gen #(
        .SYNC_DELAY (1)
    ) dut_a (
        .vga_clk (clk),
        .reset_n (rst_a),
        .vga     (va)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_DELAY (2)
    ) dut_b (
        .vga_clk (clk),
        .reset_n (rst_b),
        .vga     (vb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count}
    localparam logic [32:0] RST_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

    logic [32:0] obs_a, obs_b;
    assign obs_a = {va.DrawX, va.DrawY, va.blank, va.hs, va.vs, va.line_start, va.frame_start, va.frame_count};
    assign obs_b = {vb.DrawX, vb.DrawY, vb.blank, vb.hs, vb.vs, vb.line_start, vb.frame_start, vb.frame_count};

    typedef struct {
        int       ht, ha, vt, va, hs0, hs1, vs0, vs1, d;
        bit       on;
        int       pos;
        int       fc;
        bit       fs_prev;
        bit       hs_o, vs_o;
        bit [4:0] hsh, vsh;
    } mdl_t;

    function automatic mdl_t mdl_reset(input mdl_t m);
        m.on = 1'b0; m.pos = 0; m.fc = 0; m.fs_prev = 1'b0;
        m.hs_o = 1'b1; m.vs_o = 1'b1; m.hsh = '1; m.vsh = '1;
        return m;
    endfunction

    function automatic mdl_t mdl_init(input int ha, input int hfp, input int hsy, input int hbp,
                                      input int va_, input int vfp, input int vsy, input int vbp,
                                      input int d);
        mdl_t m;
        m.ha = ha; m.ht = ha + hfp + hsy + hbp; m.hs0 = ha + hfp; m.hs1 = ha + hfp + hsy;
        m.va = va_; m.vt = va_ + vfp + vsy + vbp; m.vs0 = va_ + vfp; m.vs1 = va_ + vfp + vsy;
        m.d = d;
        return mdl_reset(m);
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input bit en);
        int tot, x, y;
        bit rh, rv;
        tot = m.ht * m.vt;
        if (m.fs_prev) m.fc = (m.fc + 1) % 256;
        if (!m.on) begin
            if (en) begin m.on = 1'b1; m.pos = 0; end
        end else if (m.pos == tot - 1 && !en) begin
            m.on = 1'b0; m.pos = 0;
        end else begin
            m.pos = (m.pos + 1) % tot;
        end
        m.fs_prev = m.on && (m.pos == 0);
        x = m.pos % m.ht;
        y = m.pos / m.ht;
        rh = !(m.on && x >= m.hs0 && x < m.hs1);
        rv = !(m.on && y >= m.vs0 && y < m.vs1);
        m.hs_o = (m.d == 0) ? rh : m.hsh[m.d-1];
        m.vs_o = (m.d == 0) ? rv : m.vsh[m.d-1];
        m.hsh = {m.hsh[3:0], rh};
        m.vsh = {m.vsh[3:0], rv};
        return m;
    endfunction

    function automatic logic [32:0] mdl_out(input mdl_t m);
        int x, y;
        x = m.pos % m.ht;
        y = m.pos / m.ht;
        return {10'(x), 10'(y), 1'(m.on && x < m.ha && y < m.va), m.hs_o, m.vs_o,
                1'(m.on && x == 0), 1'(m.on && m.pos == 0), 8'(m.fc)};
    endfunction

    mdl_t ma, mb;
    logic [32:0] qa[$];
    logic [32:0] qb[$];

    initial begin
        ma = mdl_init(640, 16, 96, 48, 480, 10, 2, 33, 1);
        mb = mdl_init(8, 1, 2, 1, 4, 1, 1, 1, 2);
    end

    always @(posedge clk) begin
        if (rst_a) begin ma = mdl_step(ma, va.enable); qa.push_back(mdl_out(ma)); end
        if (rst_b) begin mb = mdl_step(mb, vb.enable); qb.push_back(mdl_out(mb)); end
    end

    always @(negedge clk) begin
        if (qa.size() > 0) check_eq("sb_a", obs_a, qa.pop_front());
        if (qb.size() > 0) check_eq("sb_b", obs_b, qb.pop_front());
    end

    always @(negedge rst_a) begin ma = mdl_reset(ma); qa.delete(); end
    always @(negedge rst_b) begin mb = mdl_reset(mb); qb.delete(); end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c656, cfall, c752, crise, ls1, ls2;
        int fs_n, cf_prev, period, c5, vfall, vrise, c9, hfall, hrise, found, c;

        va.enable = 1'b0;
        vb.enable = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_a", obs_a, RST_VEC);
        check_eq("reset_b", obs_b, RST_VEC);
        #1 rst_a = 1'b1; rst_b = 1'b1;

        // first edge after enable loads (0,0)
        @(negedge clk); #1 va.enable = 1'b1;
        @(negedge clk);
        check_eq("first_edge", {va.DrawX, va.DrawY, va.blank, va.frame_start}, {10'd0, 10'd0, 1'b1, 1'b1});
        repeat (639) @(negedge clk);
        check_eq("x639_active", {va.DrawX, va.blank}, {10'd639, 1'b1});
        @(negedge clk);
        check_eq("x640_blank", {va.DrawX, va.blank}, {10'd640, 1'b0});

        // hs timing and line period
        c656 = -1; cfall = -1; c752 = -1; crise = -1; ls1 = -1; ls2 = -1;
        for (int k = 641; k < 4000 && (crise < 0 || ls2 < 0); k++) begin
            @(negedge clk);
            if (va.DrawX == 10'd656 && c656 < 0) c656 = k;
            if (c656 >= 0 && cfall < 0 && !va.hs) cfall = k;
            if (cfall >= 0 && c752 < 0 && va.DrawX == 10'd752) c752 = k;
            if (c752 >= 0 && crise < 0 && va.hs) crise = k;
            if (va.line_start) begin
                if (ls1 < 0) ls1 = k; else if (ls2 < 0) ls2 = k;
            end
        end
        check_eq("hs_fall_lag", cfall - c656, 1);
        check_eq("hs_rise_lag", crise - c752, 1);
        check_eq("hs_low_len", crise - cfall, 96);
        check_eq("line_period", ls2 - ls1, 800);

        // asynchronous reset mid-line
        for (int k = 0; k < 2000 && va.DrawX != 10'd300; k++) @(negedge clk);
        check_eq("found_x300", va.DrawX, 300);
        #2 rst_a = 1'b0;
        #1 check_eq("async_reset", obs_a, RST_VEC);
        @(negedge clk); #1 rst_a = 1'b1;
        @(negedge clk);
        check_eq("restart", {va.DrawX, va.DrawY, va.frame_start, va.frame_count},
                 {10'd0, 10'd0, 1'b1, 8'd0});

        // small geometry: frame period, sync windows, frame_count wrap
        #1 vb.enable = 1'b1;
        fs_n = 0; cf_prev = -1; period = -1; c5 = -1; vfall = -1; vrise = -1;
        c9 = -1; hfall = -1; hrise = -1;
        for (int k = 1; k <= 30000 && fs_n < 257; k++) begin
            @(negedge clk);
            if (vb.frame_start) begin
                fs_n++;
                if (fs_n == 2) period = k - cf_prev;
                cf_prev = k;
                if (fs_n == 256) check_eq("fc_at_fs256", vb.frame_count, 255);
                if (fs_n == 257) check_eq("fc_at_fs257", vb.frame_count, 0);
            end
            if (fs_n == 1) begin
                if (vb.DrawY == 10'd5 && c5 < 0) c5 = k;
                if (c5 >= 0 && vfall < 0 && !vb.vs) vfall = k;
                if (vfall >= 0 && vrise < 0 && vb.vs) vrise = k;
                if (vb.DrawX == 10'd9 && c9 < 0) c9 = k;
                if (c9 >= 0 && hfall < 0 && !vb.hs) hfall = k;
                if (hfall >= 0 && hrise < 0 && vb.hs) hrise = k;
            end
        end
        check_eq("b_fs_count", fs_n, 257);
        check_eq("b_frame_period", period, 84);
        check_eq("b_vs_lag", vfall - c5, 2);
        check_eq("b_vs_low_len", vrise - vfall, 12);
        check_eq("b_hs_lag", hfall - c9, 2);
        check_eq("b_hs_low_len", hrise - hfall, 2);

        // drop enable mid-frame: drain to the last position, then idle
        for (int k = 0; k < 200 && vb.DrawY != 10'd2; k++) @(negedge clk);
        #1 vb.enable = 1'b0;
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk);
            if (vb.DrawX == 10'd11 && vb.DrawY == 10'd6) found = 1;
        end
        check_eq("drain_last", found, 1);
        @(negedge clk);
        check_eq("drain_idle", {vb.DrawX, vb.DrawY, vb.blank, vb.line_start, vb.frame_start}, 23'd0);
        repeat (5) @(negedge clk);
        check_eq("idle_hold", {vb.DrawX, vb.frame_start, vb.frame_count}, {10'd0, 1'b0, 8'd1});

        // re-enable from idle: frame_start on the next edge
        #1 vb.enable = 1'b1;
        @(negedge clk);
        check_eq("reenable_idle", {vb.DrawX, vb.DrawY, vb.frame_start}, {10'd0, 10'd0, 1'b1});

        // re-enable during drain: next frame_start exactly one frame later
        c = -1;
        for (int k = 1; k < 300 && c < 0; k++) begin
            @(negedge clk);
            if (vb.DrawY == 10'd2 && vb.enable) #1 vb.enable = 1'b0;
            else if (vb.DrawY == 10'd4 && !vb.enable) #1 vb.enable = 1'b1;
            if (vb.frame_start) c = k;
        end
        check_eq("drain_rejoin", c, 84);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
